// File: rtl/tick_counter_pkg.sv
// -----------------------------------------------------------------------------
// tick_counter_pkg
// Shared definitions for the tick_counter timebase block.
//   state_t      : run/stop FSM encoding (STOPPED=0, RUNNING=1)
//   SYNC_STAGES  : depth of the div_clock synchroniser (flops before edge detect)
// -----------------------------------------------------------------------------
package tick_counter_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage : tick_counter_pkg

// File: rtl/edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous level into the clock domain and flags its rising edge.
// The chain is s0 -> s1 (synchroniser), with s2 holding the previous s1.
// Ports:
//   clock    in  system clock, all state on its rising edge
//   reset    in  asynchronous active-low reset
//   async_in in  level from another clock domain (the divided clock)
//   rise     out combinational s1 & ~s2, one cycle per rising edge of async_in
// -----------------------------------------------------------------------------
module edge_sync
  import tick_counter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  // sync_q[0] is s0, sync_q[SYNC_STAGES-1] is s1.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s1;
  logic                   s2;

  assign s1 = sync_q[SYNC_STAGES-1];

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s2     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      s2     <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule : edge_sync

// File: rtl/tick_counter.sv
// -----------------------------------------------------------------------------
// tick_counter
// Converts the divided clock into a system-clock tick and counts ticks modulo
// MODULUS while running. Nothing downstream ever clocks off div_clock.
// Build option: define TICK_COUNTER_DOWN_EN to count down (reload MODULUS-1).
// Parameters:
//   MODULUS  count range 0..MODULUS-1, minimum 2
// Ports:
//   clock     in  system clock
//   reset     in  asynchronous active-low reset
//   div_clock in  divided clock, asynchronous in phase to clock
//   start     in  request RUNNING (ignored if stop is also high)
//   stop      in  request STOPPED
//   clear     in  load the count with its initial value
//   tick      out one-cycle pulse per div_clock rising edge
//   count     out current count, WIDTH = $clog2(MODULUS) bits
//   carry     out one-cycle pulse on wrap/reload
//   running   out high while in RUNNING
// -----------------------------------------------------------------------------
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int MODULUS = 10,
  localparam int WIDTH = $clog2(MODULUS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_clock,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             running
);

  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

`ifdef TICK_COUNTER_DOWN_EN
  localparam logic [WIDTH-1:0] COUNT_INIT = COUNT_MAX;
`else
  localparam logic [WIDTH-1:0] COUNT_INIT = '0;
`endif

  logic   rise;
  state_t state;

  edge_sync u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (div_clock),
    .rise     (rise)
  );

  // Run/stop FSM. stop wins over start when both arrive together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= STOPPED;
    end else begin
      case (state)
        STOPPED: if (start && !stop) state <= RUNNING;
        RUNNING: if (stop)           state <= STOPPED;
        default:                     state <= STOPPED;
      endcase
    end
  end

  assign running = (state == RUNNING);

  // Tick register: follows rise regardless of run state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tick <= 1'b0;
    else        tick <= rise;
  end

  // Counter qualified by the current state, so a start arriving with a rise
  // misses that edge while a stop arriving with a rise still counts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= COUNT_INIT;
      carry <= 1'b0;
    end else if (clear) begin
      count <= COUNT_INIT;
      carry <= 1'b0;
    end else if ((state == RUNNING) && rise) begin
`ifdef TICK_COUNTER_DOWN_EN
      if (count == '0) begin
        count <= COUNT_MAX;
        carry <= 1'b1;
      end else begin
        count <= count - 1'b1;
        carry <= 1'b0;
      end
`else
      if (count == COUNT_MAX) begin
        count <= '0;
        carry <= 1'b1;
      end else begin
        count <= count + 1'b1;
        carry <= 1'b0;
      end
`endif
    end else begin
      carry <= 1'b0;
    end
  end

endmodule : tick_counter

// File: tb/tb_tick_counter.sv
// -----------------------------------------------------------------------------
// tb_tick_counter
// Randomised stimulus against a behavioural model of tick_counter. The model
// keeps a history of sampled div_clock levels and derives tick/count/carry
// from the edge timing rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_tick_counter;

  localparam int MOD = 10;
  localparam int W   = $clog2(MOD);

`ifdef TICK_COUNTER_DOWN_EN
  localparam int INIT = MOD - 1;
`else
  localparam int INIT = 0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         div_clock = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic         tick;
  logic [W-1:0] count;
  logic         carry;
  logic         running;

  tick_counter #(.MODULUS(MOD)) dut (
    .clock     (clock),
    .reset     (reset),
    .div_clock (div_clock),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .tick      (tick),
    .count     (count),
    .carry     (carry),
    .running   (running)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    end
  endtask

  // Reference model state.
  bit samples[$];   // sampled div_clock levels, newest at index 0
  int m_count;
  bit m_carry;
  bit m_tick;
  bit m_run;

  // Coverage-style tallies to steer stimulus toward interesting corners.
  int n_wrap = 0;
  int n_clear_at_top = 0;

  function automatic void model_reset();
    samples = '{1'b0, 1'b0, 1'b0};
    m_count = INIT;
    m_carry = 0;
    m_tick  = 0;
    m_run   = 0;
  endfunction

  // Rise seen at the next edge: level sampled two edges back was high and the
  // one before it low.
  function automatic bit rise_next();
    return samples[1] && !samples[2];
  endfunction

  function automatic void model_step(bit d, bit st, bit sp, bit cl);
    bit r;
    r = rise_next();
    m_tick = r;
    if (cl) begin
      m_count = INIT;
      m_carry = 0;
    end else if (m_run && r) begin
`ifdef TICK_COUNTER_DOWN_EN
      if (m_count == 0) begin m_count = MOD - 1; m_carry = 1; end
      else begin m_count = m_count - 1; m_carry = 0; end
`else
      m_count = (m_count + 1) % MOD;
      m_carry = (m_count == 0);
`endif
    end else begin
      m_carry = 0;
    end
    if (!m_run && st && !sp) m_run = 1;
    else if (m_run && sp)    m_run = 0;
    samples.push_front(d);
    samples = samples[0:2];
  endfunction

  task automatic check_outputs(input string where);
    check({where, ".tick"},    int'(tick),    int'(m_tick));
    check({where, ".count"},   int'(count),   m_count);
    check({where, ".carry"},   int'(carry),   int'(m_carry));
    check({where, ".running"}, int'(running), int'(m_run));
  endtask

  // Async reset a couple of ns after an edge, checked before the next edge.
  task automatic async_reset();
    #1 reset = 1'b0;
    #1;
    check("rst.tick",    int'(tick),    0);
    check("rst.count",   int'(count),   INIT);
    check("rst.carry",   int'(carry),   0);
    check("rst.running", int'(running), 0);
    model_reset();
    #1 reset = 1'b1;
  endtask

  initial begin
    int half_left;
    int top;
    bit did_mid_reset;
    top = (INIT == 0) ? MOD - 1 : 0;
    did_mid_reset = 0;
    half_left = 4;

    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      // div_clock: half period 2..6 cycles keeps the period at least 4.
      if (--half_left == 0) begin
        div_clock = ~div_clock;
        half_left = (cyc < 400) ? 4 : $urandom_range(2, 6);
      end
      if (cyc < 200) begin
        // Idle phase: ticks only, counter must not move.
        start = 1'b0; stop = 1'b0; clear = 1'b0;
      end else begin
        start = ($urandom_range(0, 15) == 0);
        stop  = ($urandom_range(0, 39) == 0);
        clear = ($urandom_range(0, 199) == 0);
        // Aim a clear at a qualifying tick on the wrap value.
        if (m_run && rise_next() && m_count == top && $urandom_range(0, 2) == 0) begin
          clear = 1'b1;
          n_clear_at_top++;
        end
      end

      @(posedge clock);
      model_step(div_clock, start, stop, clear);
      if (m_carry) n_wrap++;
      #1;
      check_outputs("run");

      if (!did_mid_reset && cyc > 2000 && m_run && m_count == 6) begin
        did_mid_reset = 1;
        async_reset();
      end
    end

    check("seen_wrap",        int'(n_wrap > 0), 1);
    check("seen_mid_reset",   int'(did_mid_reset), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_tick_counter

// File: doc/tick_counter.md
# tick_counter

Consumes the divided clock from the ripple clock divider and turns it into logic that runs on the system clock. Each rising edge of the divided clock is synchronised and edge-detected into a one-cycle `tick`. A run/stop controlled modulo counter advances on each tick and emits a `carry` pulse on wrap. This is the timebase that display/stopwatch logic downstream uses, so no logic ever clocks off `div_clock` directly.

## Interface
- `MODULUS`, default 10: count range 0..MODULUS-1. Legal minimum is 2.
- `WIDTH`: a localparam, not overridable. Equals $clog2(MODULUS).
- `clock`  in  1: system clock. All state is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `div_clock`  in  1: divided clock from the clock divider, asynchronous to `clock` in phase.
- `start`  in  1: single-cycle request to enter RUNNING.
- `stop`  in  1: single-cycle request to enter STOPPED.
- `clear`  in  1: single-cycle request to zero the count.
- `tick`  out  1: one-cycle pulse per divided-clock rising edge.
- `count`  out  WIDTH: current count value.
- `carry`  out  1: one-cycle pulse when `count` wraps.
- `running`  out  1: high while in RUNNING.

## Operation
- Synchroniser: `div_clock` passes through `s0` and then `s1`. `s2` holds the previous value of `s1`.
- Edge: `rise = s1 & ~s2`.
- `tick` is a register loaded with `rise`. It pulses regardless of run state.
- FSM has two states, STOPPED and RUNNING. Reset state is STOPPED.
- STOPPED -> RUNNING on `start & ~stop`.
- RUNNING -> STOPPED on `stop`.
- `start` while RUNNING has no effect. `stop` while STOPPED has no effect.
- `running` is 1 exactly when the state is RUNNING. It is registered and equals the current state.
- Count update priority, evaluated per cycle:
  - `clear`: count <= 0, carry <= 0.
  - Otherwise, RUNNING & `rise`: if count == MODULUS-1 then count <= 0 and carry <= 1; else count <= count+1.
  - Otherwise: count holds, carry <= 0.
- The count is qualified by the current state, not the next state. A `start` coinciding with `rise` does not count that edge. A `stop` coinciding with `rise` does count it.
- `clear` does not change the FSM state.
- Arithmetic is unsigned in WIDTH bits. Count never reaches values at or above MODULUS.

## Timing
- Reset values: `tick`=0, `count`=0, `carry`=0, `running`=0. `s0`/`s1`/`s2`=0.
- Reset asserted mid-count clears everything immediately, asynchronously. The first edge is detected only after `div_clock` has been sampled high post-reset.
- Let edge E0 be the first `clock` edge at which `div_clock`=1 is sampled:
  - `s1`=1 after E1.
  - `tick`, the `count` change and `carry` all become visible after E2.
  - Total latency is 2 cycles after E0, plus up to 1 cycle of sampling uncertainty.
- `tick` and `carry` are exactly one `clock` cycle wide.
- Successive ticks are at least 2 cycles apart, given `div_clock` period ≥ 4 `clock` cycles. Faster `div_clock` is unsupported.
- `start`/`stop`/`clear` take effect at the next edge. `running` updates 1 cycle after the request.

## Configuration
- Macro `TICK_COUNTER_DOWN_EN`.
- When undefined, the counter counts up as above.
- When defined, the counter counts down:
  - Clear and reset load MODULUS-1, and the `count` reset value becomes MODULUS-1.
  - A qualifying tick at count 0 reloads MODULUS-1 and pulses `carry`.
  - Otherwise the count decrements.
- All other behaviour is identical.

## Structure
- Shared package `tick_counter_pkg`:
  - FSM state encoding: STOPPED=1'b0, RUNNING=1'b1.
  - Synchroniser depth constant, `SYNC_STAGES`=2.
- Sub-module `edge_sync`:
  - Holds the `s0`/`s1`/`s2` chain and the rising-edge detect.
  - Ports: `clock`, `reset`, `async_in`, `rise`.
- The top level holds the FSM, counter, and `tick`/`carry` registers.

## Test plan
- Reset, then toggle `div_clock` with period 8 and no `start`: `tick` pulses once per period, `count` stays 0, `running`=0.
- `start`, then 10 divided edges with MODULUS=10: `count` goes 1..9, then 0. `carry` is high for exactly one cycle, coincident with the 9->0 transition.
- `stop` after 3 ticks, then 5 more edges: `count` holds at 3 and `running`=0. `start` again: counting resumes at 4.
- `clear` asserted in the same cycle a tick qualifies at count 9: `count`=0, `carry` stays 0, `running` unchanged.
- `start` and `stop` asserted together from STOPPED: state stays STOPPED. `reset` driven low mid-count at 6: all outputs 0 within the same cycle, asynchronously.
- With `TICK_COUNTER_DOWN_EN` defined: reset gives `count`=9. 10 ticks give 8..0, then 9, with `carry` pulsing on the 0->9 reload.
